// File: rtl/mac_array_ctrl.sv
// Sequencer that streams key then query vectors from a 1-cycle-latency SRAM into mac_array.
// Optional K-reuse (skip LOAD_K/GAP when keys are already resident): define MAC_ARRAY_CTRL_KREUSE_EN.
module mac_array_ctrl #(
    parameter int TOTAL_K   = 8,
    parameter int TOTAL_Q   = 8,
    parameter int BW        = 8,
    parameter int COL       = 8,
    parameter int ADDR_W    = 6,
    parameter int GAP_CYC   = 21,
    parameter int DRAIN_CYC = 21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   k_base,
    input  logic [ADDR_W-1:0]   q_base,
`ifdef MAC_ARRAY_CTRL_KREUSE_EN
    input  logic                reuse_k,
`endif
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [BW*COL-1:0]   mem_rdata,
    output logic [BW*COL-1:0]   mac_in,
    output logic [1:0]          mac_inst,
    input  logic [TOTAL_K-1:0]  mac_fifo_wr,
    output logic [7:0]          psum_cnt
);

    localparam int CNT_W = 16;
    // A zero-length gap/drain still dwells one cycle in its state.
    localparam logic [CNT_W-1:0] K_LAST     = CNT_W'(TOTAL_K - 1);
    localparam logic [CNT_W-1:0] Q_LAST     = CNT_W'(TOTAL_Q - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC   > 0) ? GAP_CYC   - 1 : 0);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_K, S_GAP, S_EXEC_Q, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  k_base_q, k_base_d, q_base_q, q_base_d;
    logic [1:0]         inst_q, inst_d;
    logic [7:0]         psum_q, psum_d;
    logic               take_start, skip_k;

    assign take_start = (state_q == S_IDLE) && start;

`ifdef MAC_ARRAY_CTRL_KREUSE_EN
    logic kvalid_q, kvalid_d;
    assign skip_k   = reuse_k && kvalid_q;
    assign kvalid_d = kvalid_q || ((state_q == S_LOAD_K) && (cnt_q == K_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) kvalid_q <= 1'b0;
        else       kvalid_q <= kvalid_d;
    end
`else
    assign skip_k = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inst_d    = 2'b00;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = skip_k ? S_EXEC_Q : S_LOAD_K;
                end
            end
            S_LOAD_K: begin
                mem_rd_en = 1'b1;
                mem_addr  = k_base_q + ADDR_W'(cnt_q);
                inst_d    = 2'b01;
                cnt_d     = (cnt_q == K_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == K_LAST) state_d = S_GAP;
            end
            S_GAP: begin
                cnt_d = (cnt_q >= GAP_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q >= GAP_LAST) state_d = S_EXEC_Q;
            end
            S_EXEC_Q: begin
                mem_rd_en = 1'b1;
                mem_addr  = q_base_q + ADDR_W'(cnt_q);
                inst_d    = 2'b10;
                cnt_d     = (cnt_q == Q_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == Q_LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                cnt_d = (cnt_q >= DRAIN_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q >= DRAIN_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        k_base_d = take_start ? k_base : k_base_q;
        q_base_d = take_start ? q_base : q_base_q;
        psum_d   = psum_q;
        if (take_start)
            psum_d = 8'd0;
        else if (mac_fifo_wr[TOTAL_K-1] && (psum_q != 8'hFF))
            psum_d = psum_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            k_base_q <= '0;
            q_base_q <= '0;
            inst_q   <= 2'b00;
            psum_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_base_q <= k_base_d;
            q_base_q <= q_base_d;
            inst_q   <= inst_d;
            psum_q   <= psum_d;
        end
    end

    // inst trails the read strobe by the SRAM latency so each code lines up with its vector.
    assign mac_inst = inst_q;
    assign mac_in   = (inst_q != 2'b00) ? mem_rdata : '0;
    assign psum_cnt = psum_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl; cycle 0 is the cycle start is first driven high.
module tb_mac_array_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  k_base, q_base;
    logic        reuse_k;
    logic        busy, done, mem_rd_en;
    logic [5:0]  mem_addr;
    logic [63:0] mem_rdata;
    logic [63:0] mac_in;
    logic [1:0]  mac_inst;
    logic [7:0]  mac_fifo_wr;
    logic [7:0]  psum_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_array_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .k_base      (k_base),
        .q_base      (q_base),
`ifdef MAC_ARRAY_CTRL_KREUSE_EN
        .reuse_k     (reuse_k),
`endif
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mac_in      (mac_in),
        .mac_inst    (mac_inst),
        .mac_fifo_wr (mac_fifo_wr),
        .psum_cnt    (psum_cnt)
    );

    function automatic logic [63:0] vec(input logic [5:0] a);
        return {8{2'b10, a}};
    endfunction

    // SRAM model, one cycle read latency
    always @(posedge clk or posedge reset)
        if (reset)          mem_rdata <= '0;
        else if (mem_rd_en) mem_rdata <= vec(mem_addr);

    // mode 0: plain run, 1: extra start pulses at cycles 10 and 59, 2: K reuse (no K phase)
    task automatic check_run(input logic [5:0] kb, input logic [5:0] qb, input int mode, input string nm);
        int kl, qs, dc;
        logic eb, ed, er;
        logic [5:0] ea;
        logic [1:0] ei;
        logic [63:0] em;
        kl = (mode == 2) ? 0 : 8;
        qs = (mode == 2) ? 1 : 30;
        dc = qs + 8 + 21;
        k_base = kb;
        q_base = qb;
        for (int c = 0; c <= dc + 2; c++) begin
            @(negedge clk);
            start = (c == 0) || (mode == 1 && (c == 10 || c == 59));
            eb = (c >= 1) && (c < dc);
            ed = (c == dc);
            er = 1'b0; ea = '0; ei = 2'b00; em = '0;
            if (c >= 1 && c <= kl)          begin er = 1'b1; ea = kb + 6'(c - 1); end
            if (c >= qs && c <= qs + 7)     begin er = 1'b1; ea = qb + 6'(c - qs); end
            if (c >= 2 && c <= kl + 1)      begin ei = 2'b01; em = vec(kb + 6'(c - 2)); end
            if (c >= qs + 1 && c <= qs + 8) begin ei = 2'b10; em = vec(qb + 6'(c - qs - 1)); end
            n_chk++;
            if ({busy, done, mem_rd_en, mem_addr, mac_inst} !== {eb, ed, er, ea, ei}) begin
                n_fail++;
                $display("FAIL %s ctl cyc%0d: got b%0b d%0b r%0b a%0d i%0d, want b%0b d%0b r%0b a%0d i%0d",
                         nm, c, busy, done, mem_rd_en, mem_addr, mac_inst, eb, ed, er, ea, ei);
            end
            n_chk++;
            if (mac_in !== em) begin
                n_fail++;
                $display("FAIL %s mac_in cyc%0d: got %h want %h", nm, c, mac_in, em);
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s done: got none within 100 cycles, want pulse", nm);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; k_base = '0; q_base = '0; reuse_k = 1'b0; mac_fifo_wr = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, done, mem_rd_en, mem_addr, mac_inst, mac_in, psum_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got b%0b d%0b r%0b a%0d i%0d in%h p%0d, want all 0",
                     busy, done, mem_rd_en, mem_addr, mac_inst, mac_in, psum_cnt);
        end
        reset = 1'b0;
        k_base = 6'd5; q_base = 6'd20;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            start = (c == 0);
            mac_fifo_wr[7] = (c == 2);
        end
        n_chk++;
        if ({mem_rd_en, mem_addr, mac_inst, psum_cnt} !== {1'b1, 6'd8, 2'b01, 8'd1}) begin
            n_fail++;
            $display("FAIL reset_pre: got r%0b a%0d i%0d p%0d, want r1 a8 i1 p1",
                     mem_rd_en, mem_addr, mac_inst, psum_cnt);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, mem_rd_en, mem_addr, mac_inst, mac_in, psum_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun: got b%0b d%0b r%0b a%0d i%0d in%h p%0d, want all 0",
                     busy, done, mem_rd_en, mem_addr, mac_inst, mac_in, psum_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        check_run(6'd5, 6'd20, 0, "after_reset");
    endtask

    task automatic test_full_run;
        check_run(6'd0, 6'd8, 0, "full_run");
    endtask

    task automatic test_wrap;
        check_run(6'd62, 6'd60, 0, "wrap");
    endtask

    task automatic test_start_ignored;
        check_run(6'd0, 6'd8, 1, "start_ignored");
    endtask

    task automatic test_start_held;
        k_base = 6'd3; q_base = 6'd40;
        for (int c = 0; c <= 61; c++) begin
            @(negedge clk);
            start = 1'b1;
            if (c == 59) begin
                n_chk++;
                if ({busy, done} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL held_done: got b%0b d%0b, want b0 d1", busy, done);
                end
            end
            if (c == 60) begin
                n_chk++;
                if ({busy, done, mem_rd_en} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL held_idle: got b%0b d%0b r%0b, want 000", busy, done, mem_rd_en);
                end
            end
            if (c == 61) begin
                n_chk++;
                if ({busy, mem_rd_en, mem_addr} !== {1'b1, 1'b1, 6'd3}) begin
                    n_fail++;
                    $display("FAIL held_rerun: got b%0b r%0b a%0d, want b1 r1 a3", busy, mem_rd_en, mem_addr);
                end
            end
        end
        start = 1'b0;
        wait_done("held_second");
    endtask

    task automatic test_psum;
        k_base = 6'd0; q_base = 6'd8;
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            start = (c == 0);
            mac_fifo_wr[7] = (c >= 10) && (c < 26) && (c % 2 == 0);
            mac_fifo_wr[0] = (c % 2 == 1);
            if (c == 59) begin
                n_chk++;
                if ({done, psum_cnt} !== {1'b1, 8'd8}) begin
                    n_fail++;
                    $display("FAIL psum_at_done: got d%0b p%0d, want d1 p8", done, psum_cnt);
                end
            end
        end
        mac_fifo_wr = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 10) begin
                n_chk++;
                if (psum_cnt !== 8'd18) begin
                    n_fail++;
                    $display("FAIL psum_idle: got %0d want 18", psum_cnt);
                end
            end
            mac_fifo_wr[7] = 1'b1;
        end
        @(negedge clk);
        mac_fifo_wr = '0;
        n_chk++;
        if (psum_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL psum_sat: got %0d want 255", psum_cnt);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if ({busy, psum_cnt} !== {1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL psum_clear: got b%0b p%0d, want b1 p0", busy, psum_cnt);
        end
        wait_done("psum_run");
    endtask

`ifdef MAC_ARRAY_CTRL_KREUSE_EN
    task automatic test_kreuse;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        reuse_k = 1'b1;
        check_run(6'd16, 6'd32, 0, "reuse_cold");
        check_run(6'd16, 6'd24, 2, "reuse_warm");
        reuse_k = 1'b0;
        check_run(6'd16, 6'd32, 0, "reuse_off");
    endtask
`endif

    initial begin
        test_reset;
        test_full_run;
        test_wrap;
        test_start_ignored;
        test_start_held;
        test_psum;
`ifdef MAC_ARRAY_CTRL_KREUSE_EN
        test_kreuse;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
